// File: rtl/rx_pkg.sv
// rx_pkg: shared constants, state encodings and source tags for the rx_merge drain.
package rx_pkg;
    localparam int DATA_W = 6;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_e;

    localparam logic SRC_D0 = 1'b0;
    localparam logic SRC_D1 = 1'b1;
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: DEPTH-entry output FIFO with occupancy count, registered read data
// and almost-empty/almost-full flags against the latched thresholds.
module rx_fifo
    import rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [CNT_W-1:0]  low_i,
    input  logic [CNT_W-1:0]  high_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              almost_empty_o,
    output logic              almost_full_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd;

    always_comb begin
        rd        = rd_en_i && (count_q != '0);
        wptr_d    = wr_en_i ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d    = rd ? rptr_q + PTR_W'(1) : rptr_q;
        count_d   = count_q + CNT_W'(wr_en_i) - CNT_W'(rd);
        rd_data_d = rd ? mem_q[rptr_q] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o      = rd_data_q;
    assign count_o        = count_q;
    assign empty_o        = (count_q == '0);
    assign almost_empty_o = (count_q <= low_i);
    // A zero high threshold means "never pop", so it must not read as full.
    assign almost_full_o  = (high_i != '0) && (count_q >= high_i);
endmodule

// File: rtl/rx_merge.sv
// rx_merge: round-robin drain of destination FIFOs D0/D1 into a local output FIFO,
// throttled by thresholds latched during INIT.
module rx_merge
    import rx_pkg::*;
(
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              init,
    input  logic [CNT_W-1:0]  rx_fifo_low,
    input  logic [CNT_W-1:0]  rx_fifo_high,
    input  logic              D0_EMPTY,
    input  logic              D1_EMPTY,
    input  logic [DATA_W-1:0] D0_DATA_OUT,
    input  logic [DATA_W-1:0] D1_DATA_OUT,
    output logic              POP_D0,
    output logic              POP_D1,
    input  logic              POP_RX,
    output logic [DATA_W-1:0] DATA_OUT_RX,
    output logic              RX_EMPTY,
    output logic              RX_ALMOST_EMPTY,
    output logic              RX_ALMOST_FULL,
    output logic [3:0]        STATE
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] low_q, low_d, high_q, high_d;
    logic             inflight_q, src_q, rr_q, rr_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   pend, limit;
    logic             run, can_pop, pop0, pop1;

    always_comb begin
        run     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        pend    = {1'b0, count} + (CNT_W+1)'(inflight_q);
        limit   = ({1'b0, high_q} > (CNT_W+1)'(DEPTH)) ? (CNT_W+1)'(DEPTH) : {1'b0, high_q};
        can_pop = run && !init && (pend < limit);
        pop0    = can_pop && !D0_EMPTY && (D1_EMPTY || rr_q == SRC_D0);
        pop1    = can_pop && !D1_EMPTY && (D0_EMPTY || rr_q == SRC_D1);
        rr_d    = pop0 ? SRC_D1 : pop1 ? SRC_D0 : rr_q;
        low_d   = (state_q == ST_INIT && init) ? rx_fifo_low  : low_q;
        high_d  = (state_q == ST_INIT && init) ? rx_fifo_high : high_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
            ST_IDLE:   state_d = init ? ST_INIT : (pop0 || pop1 || count != '0) ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_d = init ? ST_INIT :
                                 (count == '0 && !inflight_q && D0_EMPTY && D1_EMPTY) ? ST_IDLE : ST_ACTIVE;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= ST_RESET;
            low_q      <= '0;
            high_q     <= '0;
            inflight_q <= 1'b0;
            src_q      <= SRC_D0;
            rr_q       <= SRC_D0;
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            high_q     <= high_d;
            inflight_q <= pop0 || pop1;
            src_q      <= pop1 ? SRC_D1 : SRC_D0;
            rr_q       <= rr_d;
        end
    end

    // The popped word appears on Dx_DATA_OUT one cycle later, even if INIT was entered meanwhile.
    rx_fifo u_fifo (
        .clk            (clk),
        .rst_n          (RESET_L),
        .wr_en_i        (inflight_q),
        .wr_data_i      (src_q == SRC_D1 ? D1_DATA_OUT : D0_DATA_OUT),
        .rd_en_i        (POP_RX),
        .low_i          (low_q),
        .high_i         (high_q),
        .rd_data_o      (DATA_OUT_RX),
        .count_o        (count),
        .empty_o        (RX_EMPTY),
        .almost_empty_o (RX_ALMOST_EMPTY),
        .almost_full_o  (RX_ALMOST_FULL)
    );

    assign POP_D0 = pop0;
    assign POP_D1 = pop1;
    assign STATE  = state_q;
endmodule

// File: tb/tb_rx_merge.sv
// tb_rx_merge: directed test of rx_merge with a small model of the D0/D1 source FIFOs.
module tb_rx_merge;
    logic       clk = 1'b0;
    logic       RESET_L = 1'b1;
    logic       init = 1'b0;
    logic [2:0] rx_fifo_low = 3'd1;
    logic [2:0] rx_fifo_high = 3'd3;
    logic       D0_EMPTY, D1_EMPTY;
    logic [5:0] d0_data = '0, d1_data = '0;
    logic       POP_D0, POP_D1;
    logic       POP_RX = 1'b0;
    logic [5:0] DATA_OUT_RX;
    logic       RX_EMPTY, RX_ALMOST_EMPTY, RX_ALMOST_FULL;
    logic [3:0] STATE;

    logic [5:0] s0 [16];
    logic [5:0] s1 [16];
    logic [3:0] h0 = '0, t0 = '0, h1 = '0, t1 = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_merge dut (
        .clk(clk), .RESET_L(RESET_L), .init(init),
        .rx_fifo_low(rx_fifo_low), .rx_fifo_high(rx_fifo_high),
        .D0_EMPTY(D0_EMPTY), .D1_EMPTY(D1_EMPTY),
        .D0_DATA_OUT(d0_data), .D1_DATA_OUT(d1_data),
        .POP_D0(POP_D0), .POP_D1(POP_D1), .POP_RX(POP_RX),
        .DATA_OUT_RX(DATA_OUT_RX), .RX_EMPTY(RX_EMPTY),
        .RX_ALMOST_EMPTY(RX_ALMOST_EMPTY), .RX_ALMOST_FULL(RX_ALMOST_FULL),
        .STATE(STATE)
    );

    assign D0_EMPTY = (h0 == t0);
    assign D1_EMPTY = (h1 == t1);

    always @(posedge clk) begin
        if (POP_D0) begin
            d0_data <= s0[h0];
            h0      <= h0 + 4'd1;
        end
        if (POP_D1) begin
            d1_data <= s1[h1];
            h1      <= h1 + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push0(input logic [5:0] v);
        s0[t0] = v;
        t0 = t0 + 4'd1;
    endtask

    task automatic push1(input logic [5:0] v);
        s1[t1] = v;
        t1 = t1 + 4'd1;
    endtask

    initial begin
        // 1: reset and init
        #1 RESET_L = 1'b0;
        #1;
        chk("rst_state", 8'(STATE), 8'h1);
        chk("rst_pops", {6'd0, POP_D1, POP_D0}, 8'h0);
        chk("rst_data", 8'(DATA_OUT_RX), 8'h0);
        chk("rst_flags", {5'd0, RX_EMPTY, RX_ALMOST_EMPTY, RX_ALMOST_FULL}, 8'b110);
        @(negedge clk);
        RESET_L = 1'b1;
        init = 1'b1;
        tick;
        chk("init_state", 8'(STATE), 8'h2);
        tick;
        init = 1'b0;
        #1 chk("init_hold", 8'(STATE), 8'h2);
        tick;
        chk("idle_state", 8'(STATE), 8'h4);
        chk("idle_pops", {6'd0, POP_D1, POP_D0}, 8'h0);
        chk("idle_empty", 8'(RX_EMPTY), 8'h1);

        // 2: single word from D0
        push0(6'b001010);
        #1 chk("t2_pop", {6'd0, POP_D1, POP_D0}, 8'b01);
        tick;
        chk("t2_active", 8'(STATE), 8'h8);
        chk("t2_nopop", {6'd0, POP_D1, POP_D0}, 8'b00);
        chk("t2_inflight_empty", 8'(RX_EMPTY), 8'h1);
        tick;
        chk("t2_captured", {6'd0, RX_EMPTY, RX_ALMOST_EMPTY}, 8'b01);
        POP_RX = 1'b1;
        tick;
        POP_RX = 1'b0;
        #1 chk("t2_data", 8'(DATA_OUT_RX), 8'b001010);
        chk("t2_drained", 8'(RX_EMPTY), 8'h1);
        tick;
        chk("t2_back_idle", 8'(STATE), 8'h4);

        // 3: both sides non-empty; pointer now favours D1
        push0(6'b001111); push0(6'b001111);
        push1(6'b111110); push1(6'b111110);
        #1 chk("t3_c0", {6'd0, POP_D1, POP_D0}, 8'b10);
        tick;
        chk("t3_c1", {6'd0, POP_D1, POP_D0}, 8'b01);
        tick;
        chk("t3_c2", {6'd0, POP_D1, POP_D0}, 8'b10);
        tick;
        chk("t3_c3_stop", {6'd0, POP_D1, POP_D0}, 8'b00);
        tick;
        chk("t3_full", {5'd0, RX_EMPTY, RX_ALMOST_EMPTY, RX_ALMOST_FULL}, 8'b001);
        chk("t3_c4_stop", {6'd0, POP_D1, POP_D0}, 8'b00);

        // 4: continuous drain while refilling
        push0(6'b000001); push0(6'b000010); push1(6'b100001);
        POP_RX = 1'b1;
        tick;
        chk("t4_d0", 8'(DATA_OUT_RX), 8'b111110);
        chk("t4_p5", {6'd0, POP_D1, POP_D0}, 8'b01);
        tick;
        chk("t4_d1", 8'(DATA_OUT_RX), 8'b001111);
        chk("t4_p6", {6'd0, POP_D1, POP_D0}, 8'b10);
        tick;
        chk("t4_d2", 8'(DATA_OUT_RX), 8'b111110);
        chk("t4_p7", {6'd0, POP_D1, POP_D0}, 8'b01);
        chk("t4_nofull", 8'(RX_ALMOST_FULL), 8'h0);
        tick;
        chk("t4_d3", 8'(DATA_OUT_RX), 8'b001111);
        chk("t4_p8", {6'd0, POP_D1, POP_D0}, 8'b01);
        tick;
        chk("t4_d4", 8'(DATA_OUT_RX), 8'b100001);
        chk("t4_p9", {6'd0, POP_D1, POP_D0}, 8'b00);
        tick;
        chk("t4_d5", 8'(DATA_OUT_RX), 8'b000001);
        tick;
        chk("t4_d6", 8'(DATA_OUT_RX), 8'b000010);
        chk("t4_empty", 8'(RX_EMPTY), 8'h1);
        tick;
        chk("t4_hold", 8'(DATA_OUT_RX), 8'b000010);
        chk("t4_idle", 8'(STATE), 8'h4);
        POP_RX = 1'b0;

        // 5: init while a pop is in flight
        push0(6'b010101);
        #1 chk("t5_pop", {6'd0, POP_D1, POP_D0}, 8'b01);
        tick;
        init = 1'b1;
        rx_fifo_low = 3'd0;
        rx_fifo_high = 3'd4;
        push0(6'b010110);
        #1 chk("t5_inhibit", {6'd0, POP_D1, POP_D0}, 8'b00);
        tick;
        chk("t5_init", 8'(STATE), 8'h2);
        chk("t5_captured", {5'd0, RX_EMPTY, RX_ALMOST_EMPTY, RX_ALMOST_FULL}, 8'b010);
        chk("t5_init_nopop", {6'd0, POP_D1, POP_D0}, 8'b00);
        tick;
        init = 1'b0;
        #1 chk("t5_new_low", 8'(RX_ALMOST_EMPTY), 8'h0);
        chk("t5_init_nopop2", {6'd0, POP_D1, POP_D0}, 8'b00);
        tick;
        chk("t5_idle", 8'(STATE), 8'h4);
        chk("t5_repop", {6'd0, POP_D1, POP_D0}, 8'b01);
        push0(6'b011000); push0(6'b011001); push0(6'b011010);
        tick;
        chk("t5_p2", {6'd0, POP_D1, POP_D0}, 8'b01);
        tick;
        chk("t5_p3", {6'd0, POP_D1, POP_D0}, 8'b01);
        tick;
        chk("t5_limit4", {6'd0, POP_D1, POP_D0}, 8'b00);
        tick;
        chk("t5_full4", {5'd0, RX_EMPTY, RX_ALMOST_EMPTY, RX_ALMOST_FULL}, 8'b001);
        chk("t5_stop", {6'd0, POP_D1, POP_D0}, 8'b00);

        // 6: asynchronous reset mid-stream, then high threshold 0
        #1 RESET_L = 1'b0;
        #1;
        chk("t6_state", 8'(STATE), 8'h1);
        chk("t6_data", 8'(DATA_OUT_RX), 8'h0);
        chk("t6_flags", {5'd0, RX_EMPTY, RX_ALMOST_EMPTY, RX_ALMOST_FULL}, 8'b110);
        chk("t6_pops", {6'd0, POP_D1, POP_D0}, 8'b00);
        @(negedge clk);
        t0 = h0;
        t1 = h1;
        RESET_L = 1'b1;
        tick;
        chk("t6_init", 8'(STATE), 8'h2);
        chk("t6_gone", 8'(RX_EMPTY), 8'h1);
        tick;
        chk("t6_idle", 8'(STATE), 8'h4);
        push0(6'b110011);
        #1 chk("t6_high0", {6'd0, POP_D1, POP_D0}, 8'b00);
        chk("t6_high0_flags", {5'd0, RX_EMPTY, RX_ALMOST_EMPTY, RX_ALMOST_FULL}, 8'b110);
        tick;
        chk("t6_stay_idle", 8'(STATE), 8'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
